// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package inst_fetch_unit_pkg;

    localparam int          cInstW       = 32;
    localparam logic [31:0] cResetPcDflt = 32'h0000_0000;

    typedef struct packed {
        logic [cInstW-1:0] inst;
        logic [31:0]       pc;
    } tFetchEntry;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous instruction buffer of fetch entries with flush; entry storage is not reset.
module fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int cDepth = 4
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iPush,
    input  tFetchEntry              iPushData,
    input  logic                    iPop,
    input  logic                    iFlush,
    output tFetchEntry              oHead,
    output logic [$clog2(cDepth):0] oCount,
    output logic                    oEmpty,
    output logic                    oFull
);

    localparam int cPtrW = $clog2(cDepth);

    tFetchEntry       r_mem [cDepth];
    logic [cPtrW-1:0] r_wrPtr;
    logic [cPtrW-1:0] r_rdPtr;
    logic [cPtrW:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // A flush overrides any push or pop presented in the same cycle.
    assign w_push = iPush && !iFlush;
    assign w_pop  = iPop && !iFlush && (r_count != '0);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (iFlush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (w_push) r_mem[r_wrPtr] <= iPushData;
    end

    assign oHead  = r_mem[r_rdPtr];
    assign oCount = r_count;
    assign oEmpty = (r_count == '0);
    assign oFull  = (r_count == (cPtrW+1)'(cDepth));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests, response buffering, redirect flush.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] cResetPc   = cResetPcDflt,
    parameter int          cFifoDepth = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    output logic              oMemReq,
    output logic [31:0]       oMemAddr,
    input  logic              iMemGnt,
    input  logic              iMemRspDv,
    input  logic [cInstW-1:0] iMemRspData,
    input  logic              iRedirect,
    input  logic [31:0]       iRedirectPc,
    output logic              oInstDv,
    output logic [cInstW-1:0] oInst,
    output logic [31:0]       oInstPc,
    input  logic              iInstRdy
);

    localparam int cCntW = $clog2(cFifoDepth) + 1;

    logic             r_run;
    logic [31:0]      r_fetchPc;
    logic [31:0]      r_rspPc;
    logic [cCntW-1:0] r_inFlight;
    logic [cCntW-1:0] r_dropCnt;

    logic [cCntW-1:0] w_fifoCount;
    logic             w_fifoEmpty;
    logic             w_fifoFull;
    tFetchEntry       w_head;
    tFetchEntry       w_pushData;
    logic [cCntW:0]   w_used;
    logic             w_grant;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;
    logic [cCntW-1:0] w_grantOne;
    logic [cCntW-1:0] w_rspOne;

    // Buffered plus owed words may never exceed the buffer depth, so every response has a slot.
    assign w_used   = {1'b0, w_fifoCount} + {1'b0, r_inFlight};
    assign oMemReq  = r_run && !iRedirect && (w_used < (cCntW+1)'(cFifoDepth));
    assign oMemAddr = r_fetchPc;

    assign w_grant    = oMemReq && iMemGnt;
    assign w_drop     = (r_dropCnt != '0);
    assign w_push     = iMemRspDv && !w_drop && !iRedirect;
    assign w_pop      = oInstDv && iInstRdy && !iRedirect;
    assign w_grantOne = cCntW'(w_grant);
    assign w_rspOne   = cCntW'(iMemRspDv);
    assign w_pushData = '{inst: iMemRspData, pc: r_rspPc};

    fetch_fifo #(
        .cDepth (cFifoDepth)
    ) u_fifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .iPush     (w_push),
        .iPushData (w_pushData),
        .iPop      (w_pop),
        .iFlush    (iRedirect),
        .oHead     (w_head),
        .oCount    (w_fifoCount),
        .oEmpty    (w_fifoEmpty),
        .oFull     (w_fifoFull)
    );

    assign oInstDv = !w_fifoEmpty;
    assign oInst   = w_fifoEmpty ? '0 : w_head.inst;
    assign oInstPc = w_fifoEmpty ? '0 : w_head.pc;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_run      <= 1'b0;
            r_fetchPc  <= cResetPc;
            r_rspPc    <= cResetPc;
            r_inFlight <= '0;
            r_dropCnt  <= '0;
        end else begin
            r_run      <= 1'b1;
            r_inFlight <= r_inFlight + w_grantOne - w_rspOne;
            if (iRedirect) begin
                // Everything still owed after this cycle's response belongs to the old path.
                r_fetchPc <= align_pc(iRedirectPc);
                r_rspPc   <= align_pc(iRedirectPc);
                r_dropCnt <= r_inFlight - w_rspOne;
            end else begin
                if (w_grant)            r_fetchPc <= r_fetchPc + 32'd4;
                if (w_push)             r_rspPc   <= r_rspPc + 32'd4;
                if (iMemRspDv && w_drop) r_dropCnt <= r_dropCnt - cCntW'(1);
            end
        end
    end

    a_noOverflow: assert property (@(posedge iClk) disable iff (iRst)
        (w_push && w_fifoFull) |-> w_pop);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based behavioural model plus directed scenarios with literal checks.
module tb_inst_fetch_unit;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

    logic        iClk, iRst;
    logic        oMemReq, iMemGnt, iMemRspDv, iRedirect, oInstDv, iInstRdy;
    logic [31:0] oMemAddr, iMemRspData, iRedirectPc, oInst, oInstPc;

    mreq_t       memq[$];
    ent_t        mfifo[$];
    logic [31:0] glog[$], plog[$], ilog[$];
    int          gcyc[$];
    int          cyc, n_cmp, n_fail, m_out, m_stale, lat, first_dv, gb, pb, gc;
    bit          gnt, rdy, last_rsp, last_dv;
    logic [31:0] m_fpc, m_rpc;

    inst_fetch_unit dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .oMemReq     (oMemReq),
        .oMemAddr    (oMemAddr),
        .iMemGnt     (iMemGnt),
        .iMemRspDv   (iMemRspDv),
        .iMemRspData (iMemRspData),
        .iRedirect   (iRedirect),
        .iRedirectPc (iRedirectPc),
        .oInstDv     (oInstDv),
        .oInst       (oInst),
        .oInstPc     (oInstPc),
        .iInstRdy    (iInstRdy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a ^ 32'hA5A5_5A5A) + 32'h0101_0101;
    endfunction

    function automatic logic [31:0] gq(input int i);
        return (i < glog.size()) ? glog[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pq(input int i);
        return (i < plog.size()) ? plog[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] iq(input int i);
        return (i < ilog.size()) ? ilog[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        memq.delete();
        mfifo.delete();
        m_out   = 0;
        m_stale = 0;
        m_fpc   = 32'h0;
        m_rpc   = 32'h0;
    endtask

    // One clock: drive inputs at the falling edge, compare against the model, then advance the model.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit   exp_req, grant, pop, rsp;
        ent_t e;
        @(negedge iClk);
        cyc++;
        iRedirect   = redir;
        iRedirectPc = rpc;
        iInstRdy    = rdy;
        iMemGnt     = gnt;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            iMemRspDv   = 1'b1;
            iMemRspData = memfn(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            iMemRspDv   = 1'b0;
            iMemRspData = $urandom;
        end
        #1;
        exp_req = !redir && (mfifo.size() + m_out < 4);
        chk("memreq", {31'b0, oMemReq}, {31'b0, exp_req});
        if (exp_req) chk("memaddr", oMemAddr, m_fpc);
        chk("instdv", {31'b0, oInstDv}, {31'b0, mfifo.size() != 0});
        chk("inst",   oInst,   (mfifo.size() != 0) ? mfifo[0].inst : 32'h0);
        chk("instpc", oInstPc, (mfifo.size() != 0) ? mfifo[0].pc   : 32'h0);

        last_rsp = iMemRspDv;
        last_dv  = oInstDv;
        if (oInstDv && first_dv < 0) first_dv = cyc;
        if (oMemReq && iMemGnt) begin
            glog.push_back(oMemAddr);
            gcyc.push_back(cyc);
            memq.push_back('{addr: oMemAddr, due: cyc + lat});
        end
        if (oInstDv && iInstRdy) begin
            plog.push_back(oInstPc);
            ilog.push_back(oInst);
        end

        grant = exp_req && gnt;
        pop   = (mfifo.size() != 0) && rdy && !redir;
        rsp   = iMemRspDv;
        if (pop) void'(mfifo.pop_front());
        if (rsp) begin
            m_out--;
            if (m_stale > 0) m_stale--;
            else if (!redir) begin
                e.inst = iMemRspData;
                e.pc   = m_rpc;
                mfifo.push_back(e);
                m_rpc += 32'd4;
            end
        end
        if (grant) begin
            m_out++;
            m_fpc += 32'd4;
        end
        if (redir) begin
            mfifo.delete();
            m_fpc   = {rpc[31:2], 2'b00};
            m_rpc   = {rpc[31:2], 2'b00};
            m_stale = m_out;
        end
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge iClk);
            #2;
        end else begin
            @(negedge iClk);
        end
        iRst = 1'b1;
        #1;
        chk("rst_memreq", {31'b0, oMemReq}, 32'h0);
        chk("rst_instdv", {31'b0, oInstDv}, 32'h0);
        chk("rst_inst",   oInst,   32'h0);
        chk("rst_instpc", oInstPc, 32'h0);
        iRedirect = 1'b0;
        iMemGnt   = 1'b0;
        iMemRspDv = 1'b0;
        iInstRdy  = 1'b0;
        model_clear();
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        iRst = 1'b0; iRedirect = 1'b0; iRedirectPc = '0; iMemGnt = 1'b0;
        iMemRspDv = 1'b0; iMemRspData = '0; iInstRdy = 1'b0;
        n_cmp = 0; n_fail = 0; cyc = 0; lat = 1; gnt = 1'b0; rdy = 1'b0;
        model_clear();

        // Streaming from reset with single-cycle memory
        do_reset(0);
        gnt = 1; rdy = 1; lat = 1; first_dv = -1;
        gb = glog.size(); pb = plog.size();
        repeat (8) cycle(0, 0);
        chk("t1_addr0", gq(gb),   32'h0);
        chk("t1_addr1", gq(gb+1), 32'h4);
        chk("t1_addr2", gq(gb+2), 32'h8);
        chk("t1_pc0",   pq(pb),   32'h0);
        chk("t1_pc1",   pq(pb+1), 32'h4);
        chk("t1_pc2",   pq(pb+2), 32'h8);
        chk("t1_inst0", iq(pb),   memfn(32'h0));
        gc = (gcyc.size() > gb) ? gcyc[gb] : -100;
        chk("t1_latency", first_dv - gc, 32'd2);

        // Decoder stalled: credits cap requests at the buffer depth
        do_reset(0);
        gnt = 1; rdy = 0; lat = 1;
        gb = glog.size(); pb = plog.size();
        repeat (10) cycle(0, 0);
        chk("t2_grants4", glog.size() - gb, 32'd4);
        chk("t2_reqlow",  {31'b0, oMemReq}, 32'h0);
        rdy = 1;
        cycle(0, 0);
        rdy = 0;
        repeat (6) cycle(0, 0);
        chk("t2_pops1",   plog.size() - pb, 32'd1);
        chk("t2_grants5", glog.size() - gb, 32'd5);

        // Redirect with three requests in flight
        do_reset(0);
        gnt = 1; rdy = 1; lat = 6;
        cycle(1, 32'h10);
        gb = glog.size();
        repeat (3) cycle(0, 0);
        cycle(1, 32'h103);
        pb = plog.size();
        repeat (20) cycle(0, 0);
        chk("t3_addr10",  gq(gb),   32'h10);
        chk("t3_addr14",  gq(gb+1), 32'h14);
        chk("t3_addr18",  gq(gb+2), 32'h18);
        chk("t3_addr100", gq(gb+3), 32'h100);
        chk("t3_pc100",   pq(pb),   32'h100);
        chk("t3_inst100", iq(pb),   memfn(32'h100));

        // Redirect coinciding with a response and a pop
        lat = 2;
        repeat (10) cycle(0, 0);
        cycle(1, 32'h200);
        chk("t4_rsp", {31'b0, last_rsp}, 32'h1);
        chk("t4_pop", {31'b0, last_dv},  32'h1);
        pb = plog.size();
        cycle(0, 0);
        chk("t4_dvlow", {31'b0, last_dv}, 32'h0);
        repeat (10) cycle(0, 0);
        chk("t4_pc200",   pq(pb), 32'h200);
        chk("t4_inst200", iq(pb), memfn(32'h200));

        // PC wrap at the top of the address space
        lat = 1;
        cycle(1, 32'hFFFF_FFF8);
        gb = glog.size(); pb = plog.size();
        repeat (10) cycle(0, 0);
        chk("t5_addr_f8", gq(gb),   32'hFFFF_FFF8);
        chk("t5_addr_fc", gq(gb+1), 32'hFFFF_FFFC);
        chk("t5_addr_0",  gq(gb+2), 32'h0);
        chk("t5_addr_4",  gq(gb+3), 32'h4);
        chk("t5_pc_f8",   pq(pb),   32'hFFFF_FFF8);
        chk("t5_pc_fc",   pq(pb+1), 32'hFFFF_FFFC);
        chk("t5_pc_0",    pq(pb+2), 32'h0);
        chk("t5_pc_4",    pq(pb+3), 32'h4);

        // Asynchronous reset in the middle of a burst
        do_reset(1);
        gb = glog.size(); pb = plog.size();
        repeat (6) cycle(0, 0);
        chk("t6_addr_rst", gq(gb), 32'h0);
        chk("t6_pc_rst",   pq(pb), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch front end. Generates word-aligned PCs and issues in-order read requests to instruction memory.
- Buffers the returned words in a small FIFO and presents them, with their PCs, to the instruction decoder through a valid/ready handshake.
- A redirect from execute (branch/jump) flushes buffered and in-flight instructions and restarts fetch at the new PC.
- Sits between the instruction memory port and the decode stage.

Parameters:
- cResetPc, 32'h0000_0000: PC of the first fetch after reset.
- cFifoDepth, 4: instruction buffer depth; also bounds in-flight requests. Power of two, at least 2.

Ports:
- iClk  input  1  clock.
- iRst  input  1  reset, asynchronous, active-high.
- oMemReq  output  1  memory read request valid.
- oMemAddr  output  32  request byte address; bits [1:0] always 0.
- iMemGnt  input  1  request accepted this cycle when oMemReq=1.
- iMemRspDv  input  1  read data valid. Responses are in order, at most one per cycle, earliest one cycle after grant.
- iMemRspData  input  32  instruction word.
- iRedirect  input  1  one-cycle pulse: flush and restart fetch.
- iRedirectPc  input  32  new PC; bits [1:0] ignored (forced 0).
- oInstDv  output  1  instruction valid to decoder.
- oInst  output  32  instruction word (FIFO head).
- oInstPc  output  32  PC of oInst.
- iInstRdy  input  1  decoder accepts; transfer occurs when oInstDv & iInstRdy.

Behaviour:
- Reset (async assert, released synchronously to iClk):
  - fetchPc = rspPc = cResetPc.
  - FIFO empty; inFlight = 0; dropCnt = 0.
  - Outputs: oMemReq=0, oInstDv=0, oInst=0, oInstPc=0.
- Cycle after reset release: oMemReq may assert with oMemAddr = cResetPc.
- Issue rule: oMemReq = !iRedirect & (fifoCount + inFlight < cFifoDepth). oMemAddr = fetchPc.
  - On grant: fetchPc += 4 (wraps modulo 2^32); inFlight += 1.
- Response handling: each iMemRspDv decrements inFlight.
  - If dropCnt > 0: discard the word and decrement dropCnt.
  - Otherwise push {iMemRspData, rspPc} into the FIFO, then rspPc += 4.
- Output: oInstDv = FIFO not empty; oInst/oInstPc = head entry, or 0 when empty.
  - Pop on oInstDv & iInstRdy.
  - Push and pop in the same cycle keep fifoCount unchanged. A full FIFO with pop and push in the same cycle is legal.
  - The credit rule guarantees a push never hits a full FIFO without a pop; that case is an assertion failure.
- Latency: grant at cycle N, response at N+k (k≥1) → oInstDv at N+k+1 when the FIFO was empty (registered push).
- Redirect (iRedirect=1), all effective next cycle:
  - FIFO flushed. Any pop or push in that cycle is ignored.
  - fetchPc = rspPc = {iRedirectPc[31:2],2'b00}.
  - dropCnt = inFlight − (iMemRspDv ? 1 : 0). This counts only responses still owed; oMemReq is 0 during redirect, so no grant is counted.
  - oInstDv = 0 in the cycle after redirect.
- Redirect while dropCnt > 0: the new dropCnt is computed by the same formula, so all older in-flight words are still dropped.
- Back-to-back redirects: the last one wins.
- Reset mid-operation: all state cleared immediately. Responses to pre-reset requests are the memory's responsibility to cancel.
- Counter widths: inFlight, dropCnt and fifoCount are $clog2(cFifoDepth)+1 bits. inFlight never exceeds cFifoDepth.

Decomposition:
- corePckg additions:
  - cResetPc default.
  - cInstW = 32.
  - typedef tFetchEntry {logic [31:0] inst; logic [31:0] pc;}.
- Sub-module fetch_fifo: synchronous FIFO of tFetchEntry with push, pop, flush, count, empty and full.
- Counters and PC registers stay in inst_fetch_unit.

Test Plan:
- Reset release, memory grants every cycle and responds in 1 cycle, iInstRdy=1 → addresses 0x0,0x4,0x8,…; oInstPc sequence 0x0,0x4,0x8 with matching data; first oInstDv 2 cycles after first grant.
- iInstRdy=0 held → exactly 4 requests granted; oMemReq stays 0 with FIFO full; after iInstRdy=1 for one cycle, exactly one new request issues.
- Three requests in flight (0x10,0x14,0x18), iRedirect with iRedirectPc=0x103 → next oMemAddr=0x100; three stale responses dropped; first oInst carries oInstPc=0x100.
- Redirect in the same cycle as a response arriving and a pop → popped entry consumed, arriving word dropped, dropCnt = inFlight−1, FIFO empty next cycle.
- fetchPc at 0xFFFF_FFFC → next request address 0x0000_0000 (wrap), oInstPc sequence matches.
- Assert iRst asynchronously mid-burst → oMemReq, oInstDv and oInst go to 0 before the next clock edge; after release, fetch restarts at cResetPc.
